data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response (legal range 0..15).
REQ-003 SHALL have the port clk, input, 1 bit, the single clock, active on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit, synchronous and active-low.
REQ-005 SHALL have the port req_valid, input, 1 bit, the pipeline MEM stage presents a request.
REQ-006 SHALL have the port req_ready, output, 1 bit, the responder accepts a request this cycle.
REQ-007 SHALL have the port req_write, input, 1 bit; 1 means store and 0 means load.
REQ-008 SHALL have the port req_addr, input, 32 bits, byte address.
REQ-009 SHALL have the port req_wdata, input, 32 bits, store data.
REQ-010 SHALL have the port req_wstrb, input, 4 bits, byte enables, where bit i enables byte i.
REQ-011 SHALL have the port rsp_valid, output, 1 bit, response available.
REQ-012 SHALL have the port rsp_ready, input, 1 bit, the initiator takes the response.
REQ-013 SHALL have the port rsp_rdata, output, 32 bits, load data.
REQ-014 SHALL have the port rsp_err, output, 1 bit, access fault.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-017 SHALL register write, addr, wdata and wstrb at acceptance; later changes on the inputs have no effect on that request.
REQ-018 SHALL move IDLE->WAIT on acceptance when LATENCY>0, loading a down-counter with LATENCY-1; IDLE->RESP when LATENCY=0.
REQ-019 SHALL decrement the counter each WAIT cycle and move WAIT->RESP on the edge where the counter is 0.
REQ-020 SHALL commit a store to the array, and capture load data, on the edge entering RESP; the first rsp_valid cycle is LATENCY+1 cycles after acceptance.
REQ-021 SHALL hold rsp_valid=1 in RESP until rsp_ready=1, then move RESP->IDLE, keeping rsp_rdata and rsp_err stable while waiting.
REQ-022 SHALL not accept a new request in the cycle rsp_ready is sampled; back-to-back throughput is one request per LATENCY+2 cycles.
REQ-023 SHALL flag a fault when req_addr[1:0]!=0 or word index req_addr[31:2]>=DEPTH_WORDS: rsp_err=1, rsp_rdata=0, no array write.
REQ-024 SHALL return rsp_rdata=0 and rsp_err=0 for a successful store.
REQ-025 SHALL, for a load in the same transaction as nothing else, return the array word at addr[31:2] as it was at the RESP-entry edge.
REQ-026 SHALL drive rsp_rdata=0 and rsp_err=0 whenever rsp_valid=0.

Reset
REQ-027 SHALL force IDLE when reset=0, with req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0.
REQ-028 SHALL abort a request reset in WAIT with no store committed; a request reset in RESP has its response dropped.
REQ-029 SHALL not reset array contents.

Configuration
REQ-030 SHALL, with DATA_MEM_BYTE_STROBE_EN defined, write only the bytes enabled by req_wstrb, with req_wstrb=0 making the store a no-op that still returns a response.
REQ-031 SHALL, without DATA_MEM_BYTE_STROBE_EN, write the full word on every store and ignore req_wstrb.

Structure
REQ-032 SHALL place the state enum, the LATENCY default and the max-latency constant in shared package dmem_pkg.
REQ-033 SHALL instantiate the storage as one sub-module dmem_array (synchronous write and read port, per-byte enables), with the FSM and counter in data_mem_responder.

Verification
REQ-034 SHALL cover: LATENCY=2, store 0xDEADBEEF to 0x10, load 0x10 -> rsp_valid 3 cycles after acceptance, rdata 0xDEADBEEF, err 0.
REQ-035 SHALL cover: LATENCY=0, load 0x0 after reset -> rsp_valid on the next cycle, with req_ready low while in RESP.
REQ-036 SHALL cover: load 0x13 (misaligned) and load 0x400 with DEPTH_WORDS=256 -> err 1, rdata 0, array unchanged.
REQ-037 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid, rdata and err stable, with no new acceptance.
REQ-038 SHALL cover: with STROBE_EN, word 0x11223344 and store 0xAABBCCDD with wstrb=0b0101 -> load returns 0x11BB33DD; without STROBE_EN -> 0xAABBCCDD.
REQ-039 SHALL cover: reset asserted during WAIT of a store -> outputs zero, later load returns the old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, latency limits, fault check.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package dmem_pkg;

  // FSM encoding, kept as plain constants so older tools and bus monitors can decode it.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Default and maximum number of wait cycles between acceptance and response.
  localparam int LATENCY_DEFAULT = 2;
  localparam int LATENCY_MAX     = 15;

  // Wide enough to hold LATENCY_MAX - 1.
  localparam int CNT_W = 4;

  // Bytes per stored word.
  localparam int WORD_BYTES = 4;

  // An access faults when it is not word aligned or its word index is past the array.
  function automatic logic addr_fault(input logic [31:0] addr, input int unsigned depth_words);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (addr[1:0] != 2'b00) || (word_idx >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Latency: write commits and read data registers on the same rising edge (read-before-write).
// Backpressure: none; the controller owns all sequencing.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic                  clk,
  input  logic [AW-1:0]         idx,
  input  logic                  wr_en,
  input  logic [WORD_BYTES-1:0] wr_be,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and registered read; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (wr_be[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipeline MEM stage: one outstanding request, fixed LATENCY wait.
// Latency: first rsp_valid cycle is LATENCY+1 cycles after acceptance; one request per LATENCY+2 cycles.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready. Option: DATA_MEM_BYTE_STROBE_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Wait-counter preload; unused when LATENCY is 0 because WAIT is skipped.
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  localparam bit               BYPASS   = (LATENCY == 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Request captured at acceptance.
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  // Response attributes captured on the edge entering RESP.
  logic err_q;
  logic load_q;

  logic        accept;
  logic        enter_resp;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        sel_fault;
  logic        arr_wr_en;
  logic        arr_rd_en;
  logic [3:0]  arr_be;
  logic [31:0] arr_rdata;

  assign req_ready = reset && (state == ST_IDLE);
  assign accept    = req_valid && req_ready;

  // With no wait cycles the array is touched on the acceptance edge itself, so the live
  // request fields are used; otherwise the captured copy drives the array.
  assign sel_write = BYPASS ? req_write : r_write;
  assign sel_addr  = BYPASS ? req_addr  : r_addr;
  assign sel_wdata = BYPASS ? req_wdata : r_wdata;
  assign sel_wstrb = BYPASS ? req_wstrb : r_wstrb;

  assign sel_fault = addr_fault(sel_addr, DEPTH_WORDS);

  // A reset in WAIT suppresses this edge, so an aborted store never reaches the array.
  assign enter_resp = reset &&
                      ((BYPASS && accept) ||
                       (!BYPASS && (state == ST_WAIT) && (cnt == '0)));

  assign arr_wr_en = enter_resp &&  sel_write && !sel_fault;
  assign arr_rd_en = enter_resp && !sel_write && !sel_fault;

`ifdef DATA_MEM_BYTE_STROBE_EN
  // Only enabled bytes are written; an all-zero strobe still completes with a response.
  assign arr_be = sel_wstrb;
`else
  // Full-word stores; the strobe is carried but has no effect.
  logic unused_wstrb;
  assign unused_wstrb = ^sel_wstrb;
  assign arr_be       = 4'hF;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .idx     (sel_addr[AW+1:2]),
    .wr_en   (arr_wr_en),
    .wr_be   (arr_be),
    .wr_data (sel_wdata),
    .rd_en   (arr_rd_en),
    .rd_data (arr_rdata)
  );

  // Capture the request so later input changes cannot affect it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Control FSM and wait down-counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (BYPASS) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Latch fault and load/store kind alongside the array access so the response stays stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end else if (enter_resp) begin
      err_q  <= sel_fault;
      load_q <= !sel_write;
    end
  end

  // Outputs are zero outside a valid response; stores and faults return zero data.
  assign rsp_valid = reset && (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && load_q && !err_q) ? arr_rdata : 32'h0;

endmodule
